// File: rtl/matrix_fifo_ctrl.sv
// Load/drain sequencer for one fifo_matrix: accepts an N x N matrix on a valid/ready stream,
// then replays it row-major with position tags. Define CTRL_TIMEOUT_EN to abort stalled loads.
module matrix_fifo_ctrl #(
    parameter int DW      = 8,
    parameter int NW      = 4,
    parameter int MAX_N   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] N,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          fifo_push,
    output logic          fifo_pop,
    output logic [DW-1:0] fifo_din,
    output logic [NW-1:0] fifo_N,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    input  logic          fifo_ready,
    input  logic [DW-1:0] fifo_dout,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [NW-1:0] out_row,
    output logic [NW-1:0] out_col,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, POP, SHOW} state_t;

    localparam logic [NW:0] MAX_NV = (NW+1)'(MAX_N);

    state_t          state, state_nx;
    logic [NW-1:0]   n_q, row_q, col_q;
    logic [2*NW-1:0] ld_cnt, nn;
    logic [DW-1:0]   data_q;
    logic            held_q, err_q;
    logic            n_ok, load_ok, accept_in, last_load, overflow;
    logic            out_acc, col_end, last_elem, pop_err, to_hit, err_evt;

    assign n_ok      = (N != '0) && ({1'b0, N} <= MAX_NV);
    assign nn        = {{NW{1'b0}}, n_q} * {{NW{1'b0}}, n_q};
    assign load_ok   = (state == LOAD) && !fifo_full && (ld_cnt < nn);
    assign accept_in = load_ok && in_valid;
    assign last_load = accept_in && (ld_cnt == nn - 1'b1);
    assign overflow  = (state == LOAD) && fifo_full && in_valid && (ld_cnt < nn);
    assign out_acc   = (state == SHOW) && out_ready;
    assign col_end   = (col_q == n_q - NW'(1));
    assign last_elem = col_end && (row_q == n_q - NW'(1));
    assign pop_err   = (state == POP) && fifo_empty;
    assign err_evt   = ((state == IDLE) && start && !n_ok) || overflow || to_hit || pop_err;

`ifdef CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    assign to_hit = (state == LOAD) && !in_valid && (to_cnt == TW'(TIMEOUT - 1));

    // Counts consecutive idle LOAD cycles; any cycle with in_valid restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != LOAD || in_valid) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start && n_ok) state_nx = LOAD;
            LOAD: begin
                if (overflow || to_hit) state_nx = IDLE;
                else if (last_load)     state_nx = WAIT_RDY;
            end
            WAIT_RDY: if (fifo_ready) state_nx = POP;
            POP:      state_nx = fifo_empty ? IDLE : SHOW;
            SHOW:     if (out_ready) state_nx = last_elem ? IDLE : POP;
            default:  state_nx = IDLE;
        endcase
    end

    // Job bookkeeping: dimension, load count, output position, held output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q    <= '0;
            ld_cnt <= '0;
            row_q  <= '0;
            col_q  <= '0;
            data_q <= '0;
            held_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= err_evt;
            held_q <= (state == SHOW) && !out_ready;
            if ((state == SHOW) && !held_q) begin
                data_q <= fifo_dout;
            end
            if ((state == IDLE) && start && n_ok) begin
                n_q    <= N;
                ld_cnt <= '0;
                row_q  <= '0;
                col_q  <= '0;
            end else if (to_hit) begin
                ld_cnt <= '0;
            end else if (accept_in) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (out_acc) begin
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_q + NW'(1);
                end else begin
                    col_q <= col_q + NW'(1);
                end
            end
        end
    end

    // The first SHOW cycle forwards fifo_dout directly; stalled cycles replay the captured copy.
    always_comb begin
        in_ready  = load_ok;
        fifo_push = accept_in;
        fifo_din  = accept_in ? in_data : '0;
        fifo_pop  = (state == POP) && !fifo_empty;
        fifo_N    = n_q;
        out_valid = (state == SHOW);
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        if (state == SHOW) begin
            out_data = held_q ? data_q : fifo_dout;
            out_row  = row_q;
            out_col  = col_q;
            out_last = col_end;
        end
        busy  = (state != IDLE);
        done  = out_acc && last_elem;
        error = err_q;
    end

endmodule

// File: tb/tb_matrix_fifo_ctrl.sv
// Bench for matrix_fifo_ctrl: behavioural fifo_matrix model, job table and scoreboard,
// plus hand sequences for mid-drain reset and load timeout (CTRL_TIMEOUT_EN aware).
module tb_matrix_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_ready, out_ready;
    logic [3:0] N;
    logic [7:0] in_data;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ready;
    logic [7:0] fifo_din, fifo_dout, out_data;
    logic [3:0] fifo_N, out_row, out_col;
    logic       out_valid, out_last, busy, done, error;

    always #5 clk = ~clk;

    matrix_fifo_ctrl #(.DW(8), .NW(4), .MAX_N(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .N(N),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_din(fifo_din), .fifo_N(fifo_N),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_ready(fifo_ready),
        .fifo_dout(fifo_dout),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error)
    );

    // Behavioural fifo_matrix: 64 entries, registered data_out, ready once N*N are stored.
    logic [7:0] fq[$];
    int         fcount;

    assign fifo_full  = (fcount >= 64);
    assign fifo_empty = (fcount == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fcount     <= 0;
            fifo_dout  <= 8'h00;
            fifo_ready <= 1'b0;
        end else begin
            if (fifo_push) fq.push_back(fifo_din);
            if (fifo_pop && fq.size() > 0) fifo_dout <= fq.pop_front();
            fcount <= fq.size();
            if (fifo_push && fq.size() == int'(fifo_N) * int'(fifo_N)) fifo_ready <= 1'b1;
            if (fq.size() == 0) fifo_ready <= 1'b0;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic [3:0] r;
        logic [3:0] c;
        logic       l;
    } exp_t;

    typedef struct {
        logic [3:0] n;
        logic [7:0] base;
        logic [7:0] stp;
        int         bp;
        bit         gaps;
        bit         exp_err;
    } job_t;

    exp_t sb[$];
    int   comps = 0, fails = 0;
    int   n_push = 0, n_pop = 0, n_err = 0, n_done = 0;
    bit   acc_in, prev_hold;
    logic [7:0] prev_d;
    logic [3:0] prev_r, prev_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        comps++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {28'h0, in_ready, fifo_push, fifo_pop, fifo_din, fifo_N, out_valid, out_data,
                out_row, out_col, out_last, busy, done, error};
    endfunction

    task automatic monitor();
        exp_t e;
        acc_in = in_valid && in_ready;
        if (fifo_push) n_push++;
        if (fifo_pop)  n_pop++;
        if (error)     n_err++;
        if (done)      n_done++;
        if (out_valid) begin
            if (prev_hold) begin
                chk("hold_data", out_data, prev_d);
                chk("hold_rowcol", {out_row, out_col}, {prev_r, prev_c});
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_rowcol", {out_row, out_col}, {e.r, e.c});
                    chk("out_last", out_last, e.l);
                    chk("done_on_final", done, sb.size() == 0);
                end
            end
        end else if (done) begin
            chk("done_without_valid", 1, 0);
        end
        prev_hold = out_valid && !out_ready;
        prev_d = out_data;
        prev_r = out_row;
        prev_c = out_col;
    endtask

    task automatic step();
        #1;
        monitor();
        @(negedge clk);
    endtask

    task automatic feed(input job_t j, input int count);
        int k = 0, guard = 0;
        int n = int'(j.n);
        exp_t e;
        while (k < count && guard < 2000) begin
            in_valid = j.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = j.base + j.stp * 8'(k);
            step();
            if (acc_in) begin
                e.d = in_data;
                e.r = 4'(k / n);
                e.c = 4'(k % n);
                e.l = ((k % n) == n - 1);
                sb.push_back(e);
                k++;
            end
            guard++;
        end
        in_valid = 1'b0;
        chk("load_count", k, count);
    endtask

    task automatic run_job(input job_t j);
        int p0 = n_push, q0 = n_pop, e0 = n_err, d0 = n_done;
        int nn = int'(j.n) * int'(j.n);
        int guard = 0;
        start = 1'b1;
        N = j.n;
        step();
        start = 1'b0;
        if (j.exp_err) begin
            repeat (3) step();
            chk("illegal_err", n_err - e0, 1);
            chk("illegal_busy", busy, 0);
            chk("illegal_push_pop", n_push - p0 + n_pop - q0, 0);
        end else begin
            feed(j, nn);
            while (n_done == d0 && guard < 3000) begin
                case (j.bp)
                    1:       out_ready = (guard % 2 == 0);
                    2:       out_ready = ($urandom_range(0, 2) != 0);
                    default: out_ready = 1'b1;
                endcase
                step();
                guard++;
            end
            out_ready = 1'b0;
            chk("done_count", n_done - d0, 1);
            #1;
            chk("busy_after_done", busy, 0);
            chk("push_count", n_push - p0, nn);
            chk("pop_count", n_pop - q0, nn);
            chk("no_error", n_err - e0, 0);
            chk("sb_empty", sb.size(), 0);
            step();
        end
    endtask

    job_t jobs[7];

    initial begin
        job_t j;
        int   e0, guard;
        jobs[0] = '{4'd2, 8'h11, 8'h11, 0, 1'b0, 1'b0};
        jobs[1] = '{4'd3, 8'h01, 8'h01, 1, 1'b0, 1'b0};
        jobs[2] = '{4'd0, 8'h00, 8'h00, 0, 1'b0, 1'b1};
        jobs[3] = '{4'd9, 8'h00, 8'h00, 0, 1'b0, 1'b1};
        jobs[4] = '{4'd1, 8'hA5, 8'h00, 0, 1'b0, 1'b0};
        jobs[5] = '{4'd8, 8'h80, 8'h03, 2, 1'b1, 1'b0};
        jobs[6] = '{4'd4, 8'hF0, 8'h07, 2, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; N = 4'd0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        prev_hold = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_job(jobs[i]);

        // Reset after two elements have been drained, then a clean N=2 job.
        j = jobs[0];
        start = 1'b1; N = 4'd2;
        step();
        start = 1'b0;
        feed(j, 4);
        guard = 0;
        out_ready = 1'b1;
        while (sb.size() > 2 && guard < 200) begin
            step();
            guard++;
        end
        chk("mid_drain_progress", sb.size(), 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_drain_reset_outputs", all_outs(), 64'h0);
        sb.delete();
        out_ready = 1'b0;
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        j.base = 8'h5A;
        j.stp  = 8'h01;
        run_job(j);

        // Load stalls after one element.
        e0 = n_err;
        start = 1'b1; N = 4'd2;
        step();
        start = 1'b0;
        feed(j, 1);
`ifdef CTRL_TIMEOUT_EN
        guard = 0;
        while (n_err == e0 && guard < 40) begin
            step();
            guard++;
        end
        chk("timeout_error", n_err - e0, 1);
        #1;
        chk("timeout_idle", busy, 0);
`else
        repeat (100) step();
        chk("no_timeout_error", n_err - e0, 0);
        chk("no_timeout_busy", {busy, in_ready}, 2'b11);
`endif
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule
